// File: rtl/refresh_scheduler_if.sv
// Host-side handshake and refresh status bundle of the refresh scheduler.
// The scheduler takes the slave modport; the host/command path takes master.
interface refresh_scheduler_if;
  logic       host_req;
  logic       host_busy;
  logic       host_grant;
  logic       ref_start;
  logic       ref_active;
  logic [3:0] pending;
  logic       urgent;
  logic       overflow;

  modport master (
    output host_req,
    output host_busy,
    input  host_grant,
    input  ref_start,
    input  ref_active,
    input  pending,
    input  urgent,
    input  overflow
  );

  modport slave (
    input  host_req,
    input  host_busy,
    output host_grant,
    output ref_start,
    output ref_active,
    output pending,
    output urgent,
    output overflow
  );
endinterface

// File: rtl/refresh_scheduler.sv
// DRAM refresh scheduler: counts refresh intervals, keeps a bounded count of
// owed refreshes, and arbitrates the bus between the host and refresh.
// Refresh is postponed while the host is requesting, unless the backlog has
// reached the urgent level, in which case the host is preempted.
module refresh_scheduler #(
  parameter int TREFI    = 7800,
  parameter int TRFC     = 104,
  parameter int MAX_PEND = 8,
  parameter int URG_TH   = 6
) (
  input  logic               clk,
  input  logic               rst,
  refresh_scheduler_if.slave bus
);

  localparam int CW = (TREFI > 1) ? $clog2(TREFI) : 1;
  localparam int TW = (TRFC > 1) ? $clog2(TRFC) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(TREFI - 1);
  localparam logic [TW-1:0] TRFC_M1  = TW'(TRFC - 1);
  localparam logic [3:0]    PEND_MAX = 4'(MAX_PEND);
  localparam logic [3:0]    URG_LVL  = 4'(URG_TH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    REFRESH = 2'd2,
    WAIT    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    pending_q, pending_d;
  logic          urgent_q;
  logic          overflow_q, overflow_d;

  logic          tick;
  logic          dec;
  logic          want_ref;
  logic          grant_c, start_c, active_c;

  // The wrap cycle of the interval counter is the refresh tick.
  assign tick     = (cnt_q == CNT_MAX);
  // The single REFRESH cycle retires one owed refresh.
  assign dec      = (state_q == REFRESH);
  // Refresh wins in IDLE when something is owed and either the backlog is
  // urgent or the host is not asking for the bus.
  assign want_ref = (pending_q != 4'd0) && (urgent_q || !bus.host_req);

  // Free-running interval counter, independent of the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Owed-refresh accounting; a tick and a retire in the same cycle cancel.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (tick && !dec) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 4'd1;
      end
    end else if (!tick && dec) begin
      pending_d = pending_q - 4'd1;
    end
  end

  // Registered backlog, urgency flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= 4'd0;
      urgent_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      urgent_q   <= (pending_d >= URG_LVL);
      overflow_q <= overflow_d;
    end
  end

  // FSM state and recovery timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic; the WAIT timer counts TRFC-1 down to 0 so WAIT spans
  // exactly TRFC cycles.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (want_ref) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.host_busy) begin
          state_d = REFRESH;
        end
      end
      REFRESH: begin
        timer_d = TRFC_M1;
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; the host is only ever granted from IDLE.
  always_comb begin
    grant_c  = 1'b0;
    start_c  = 1'b0;
    active_c = 1'b0;
    case (state_q)
      IDLE: begin
        grant_c = bus.host_req && !want_ref;
      end
      DRAIN: begin
        active_c = 1'b1;
      end
      REFRESH: begin
        start_c  = 1'b1;
        active_c = 1'b1;
      end
      WAIT: begin
        active_c = 1'b1;
      end
      default: begin
        grant_c  = 1'b0;
        start_c  = 1'b0;
        active_c = 1'b0;
      end
    endcase
  end

  assign bus.host_grant = grant_c;
  assign bus.ref_start  = start_c;
  assign bus.ref_active = active_c;
  assign bus.pending    = pending_q;
  assign bus.urgent     = urgent_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Randomized bench for refresh_scheduler. A behavioural model, stepped once
// per cycle by the stimulus process, pushes the expected outputs of every
// cycle into a queue; a monitor on the falling edge pops and compares.
module tb_refresh_scheduler;

  localparam int TREFI    = 16;
  localparam int TRFC     = 4;
  localparam int MAX_PEND = 8;
  localparam int URG_TH   = 6;

  typedef struct packed {
    logic       grant;
    logic       start;
    logic       active;
    logic [3:0] pend;
    logic       urg;
    logic       ovf;
  } obs_t;

  logic clk;
  logic rst;
  refresh_scheduler_if bus ();

  refresh_scheduler #(
    .TREFI(TREFI), .TRFC(TRFC), .MAX_PEND(MAX_PEND), .URG_TH(URG_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model state: owed refreshes, sticky loss flag, waiting-for-bus flag,
  // remaining cycles of the refresh+recovery window, cycles since reset.
  int m_pend, m_ovf, m_drain, m_win, m_t;

  task automatic model_reset();
    m_pend  = 0;
    m_ovf   = 0;
    m_drain = 0;
    m_win   = 0;
    m_t     = 0;
  endtask

  // One clock cycle: drive inputs, record the expected outputs for this
  // cycle, then advance the model to the next cycle.
  task automatic step(input bit req, input bit busy, input bit r);
    obs_t e;
    bit urg, active, start, want, tick;
    @(posedge clk);
    #1;
    bus.host_req  = req;
    bus.host_busy = busy;
    rst           = r;
    cyc++;

    urg    = (m_pend >= URG_TH);
    active = (m_drain != 0) || (m_win > 0);
    start  = (m_win == TRFC + 1);
    want   = (m_pend > 0) && (urg || !req);
    e.grant  = !active && req && !want;
    e.start  = start;
    e.active = active;
    e.pend   = 4'(m_pend);
    e.urg    = urg;
    e.ovf    = (m_ovf != 0);
    exp_q.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      tick = ((m_t % TREFI) == TREFI - 1);
      m_t++;
      if (tick && !start) begin
        if (m_pend == MAX_PEND) m_ovf = 1;
        else m_pend++;
      end else if (!tick && start) begin
        m_pend--;
      end
      if (m_win > 0) begin
        m_win--;
      end else if (m_drain != 0) begin
        if (!busy) begin
          m_drain = 0;
          m_win   = TRFC + 1;
        end
      end else if (!active && want) begin
        m_drain = 1;
      end
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation each cycle.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.grant  = bus.host_grant;
      a.start  = bus.ref_start;
      a.active = bus.ref_active;
      a.pend   = bus.pending;
      a.urg    = bus.urgent;
      a.ovf    = bus.overflow;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got grant=%b start=%b active=%b pend=%0d urg=%b ovf=%b, expected grant=%b start=%b active=%b pend=%0d urg=%b ovf=%b",
                 $time, a.grant, a.start, a.active, a.pend, a.urg, a.ovf,
                 e.grant, e.start, e.active, e.pend, e.urg, e.ovf);
      end else if (a.start) begin
        $display("refresh t=%0t pending=%0d overflow=%b", $time, a.pend, a.ovf);
      end
    end
  end

  initial begin
    bit hit;
    rst           = 1'b1;
    bus.host_req  = 1'b0;
    bus.host_busy = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Idle host: regular refreshes, backlog returns to zero.
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b0);
    // Continuous host: backlog climbs to urgent, then host is preempted.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
    // Host busy for a long time: drain stalls, backlog saturates, overflow.
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    // Bus released; overflow must stay sticky while the backlog drains.
    for (int i = 0; i < 150; i++) step(1'b0, 1'b0, 1'b0);
    // Short busy bursts to stretch DRAIN by a few cycles.
    for (int i = 0; i < 80; i++) step(1'b0, 1'($urandom_range(0, 7) < 5), 1'b0);
    // Fully random traffic with occasional resets.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 127) == 0));
    // Reset pulses landing in the middle of the recovery window.
    for (int k = 0; k < 3; k++) begin
      hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
        step(1'b0, 1'b0, 1'b0);
        if (m_win == 2) hit = 1'b1;
      end
      if (!hit) begin
        checks++;
        errors++;
        $display("FAIL wait_window: got no WAIT phase within 60 cycles, expected one");
      end
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    end

    // Let the monitor consume the last expectations, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: got %0d unconsumed expectations, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
